// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register addresses, cause codes and field positions
package cp0_pkg;
    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam int IE_BIT  = 0;
    localparam int IM_LSB  = 8;
    localparam int IP_LSB  = 8;
    localparam int EXC_LSB = 2;
    localparam int EXC_MSB = 6;
endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - pipeline-to-CP0 exception/register bus
interface cp0_exc_ctrl_if #(
    parameter int W    = 32,
    parameter int NIRQ = 6
);
    logic [NIRQ-1:0] irq;
    logic            exc_req;
    logic [4:0]      exc_code;
    logic [W-1:0]    pc;
    logic            mtc0;
    logic [4:0]      addr;
    logic [W-1:0]    wdata;
    logic            eret;
    logic [W-1:0]    rdata;
    logic            trap;
    logic [W-1:0]    epc_out;

    modport master (
        output irq, exc_req, exc_code, pc, mtc0, addr, wdata, eret,
        input  rdata, trap, epc_out
    );

    modport slave (
        input  irq, exc_req, exc_code, pc, mtc0, addr, wdata, eret,
        output rdata, trap, epc_out
    );
endinterface

// File: rtl/cp0_reg.sv
// rtl/cp0_reg.sv - W-bit register with 2:1 load mux, enable and async clear
module cp0_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clrn,
    input  logic         en,
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else if (en) begin
            q <= sel ? d1 : d0;
        end
    end
endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 STATUS/CAUSE/EPC with exception and interrupt trap FSM
module cp0_exc_ctrl
    import cp0_pkg::*;
#(
    parameter int              W        = 32,
    parameter int              NIRQ     = 6,
    parameter logic [NIRQ-1:0] IRQ_EDGE = '0
) (
    input  logic          clk,
    input  logic          clrn,
    cp0_exc_ctrl_if.slave bus
);
    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_TRAP = 1'b1;

    logic [0:0]      state;
    logic [NIRQ-1:0] irq_q, ip, im, ip_next, edge_clr;
    logic            ie, in_run, int_pend, take, eret_run;
    logic            status_wr, cause_wr, epc_wr, status_en;
    logic [4:0]      exc_code, code_sw;
    logic [W-1:0]    status_q, cause_q, epc_q;
    logic [W-1:0]    status_d0, status_d1, cause_d0, cause_d1;

    assign ie       = status_q[IE_BIT];
    assign im       = status_q[IM_LSB +: NIRQ];
    assign ip       = cause_q[IP_LSB +: NIRQ];
    assign exc_code = cause_q[EXC_MSB:EXC_LSB];

    assign status_wr = bus.mtc0 && (bus.addr == ADDR_STATUS);
    assign cause_wr  = bus.mtc0 && (bus.addr == ADDR_CAUSE);
    assign epc_wr    = bus.mtc0 && (bus.addr == ADDR_EPC);

    assign in_run   = (state == S_RUN);
    assign int_pend = ie && |(ip & im);
    assign take     = in_run && (bus.exc_req || int_pend);
    assign eret_run = in_run && bus.eret;

    // Edge lines latch a rising edge; a same-cycle software clear loses to a new edge.
    assign edge_clr = cause_wr ? ~bus.wdata[IP_LSB +: NIRQ] : '0;
    assign ip_next  = (~IRQ_EDGE & bus.irq)
                    | (IRQ_EDGE & ((bus.irq & ~irq_q) | (ip & ~edge_clr)));

    always_comb begin
        status_d0 = '0;
        status_d0[IE_BIT] = bus.wdata[IE_BIT];
        status_d0[IM_LSB +: NIRQ] = bus.wdata[IM_LSB +: NIRQ];

        // Hardware path: trap clears IE, otherwise Eret sets it; IM still follows Mtc0.
        status_d1 = '0;
        status_d1[IE_BIT] = ~take;
        status_d1[IM_LSB +: NIRQ] = status_wr ? bus.wdata[IM_LSB +: NIRQ] : im;

        code_sw  = cause_wr ? bus.wdata[EXC_MSB:EXC_LSB] : exc_code;
        cause_d0 = '0;
        cause_d0[EXC_MSB:EXC_LSB] = code_sw;
        cause_d0[IP_LSB +: NIRQ]  = ip_next;

        cause_d1 = cause_d0;
        cause_d1[EXC_MSB:EXC_LSB] = bus.exc_req ? bus.exc_code : EXC_INT;
    end

    assign status_en = status_wr || take || eret_run;

    cp0_reg #(.W(W)) u_status (
        .clk (clk), .clrn(clrn), .en(status_en), .sel(take || eret_run),
        .d0  (status_d0), .d1(status_d1), .q(status_q)
    );

    cp0_reg #(.W(W)) u_cause (
        .clk (clk), .clrn(clrn), .en(1'b1), .sel(take),
        .d0  (cause_d0), .d1(cause_d1), .q(cause_q)
    );

    cp0_reg #(.W(W)) u_epc (
        .clk (clk), .clrn(clrn), .en(take || epc_wr), .sel(take),
        .d0  (bus.wdata), .d1(bus.pc), .q(epc_q)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= S_RUN;
            irq_q <= '0;
        end else begin
            state <= take ? S_TRAP : S_RUN;
            irq_q <= bus.irq;
        end
    end

    always_comb begin
        case (bus.addr)
            ADDR_STATUS: bus.rdata = status_q;
            ADDR_CAUSE:  bus.rdata = cause_q;
            ADDR_EPC:    bus.rdata = epc_q;
            default:     bus.rdata = '0;
        endcase
    end

    assign bus.trap    = (state == S_TRAP);
    assign bus.epc_out = epc_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - directed-vector bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;
    import cp0_pkg::*;

    logic clk;
    logic clrn;
    int   total;
    int   bad;
    logic [31:0] v;

    cp0_exc_ctrl_if #(.W(32), .NIRQ(6)) bus ();

    cp0_exc_ctrl #(.W(32), .NIRQ(6), .IRQ_EDGE(6'b000100)) dut (
        .clk (clk),
        .clrn(clrn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.mtc0  = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
    endtask

    task automatic idle();
        bus.mtc0    = 1'b0;
        bus.exc_req = 1'b0;
        bus.eret    = 1'b0;
        bus.wdata   = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clrn  = 1'b0;
        bus.irq = '0; bus.exc_code = '0; bus.pc = '0; bus.addr = '0;
        idle();
        step(); step();

        // reset state
        chk("rst_trap", {31'd0, bus.trap}, 32'd0);
        rd(ADDR_STATUS, v); chk("rst_status", v, 32'h0);
        rd(ADDR_CAUSE, v);  chk("rst_cause", v, 32'h0);
        rd(ADDR_EPC, v);    chk("rst_epc", v, 32'h0);
        rd(5'd3, v);        chk("rd_other", v, 32'h0);
        clrn = 1'b1;
        step();

        // level interrupt trap
        wr(ADDR_STATUS, 32'h0000_0101);
        step();
        idle();
        bus.irq = 6'b000001; bus.pc = 32'h40;
        step();
        chk("int_wait", {31'd0, bus.trap}, 32'd0);
        step();
        chk("int_trap", {31'd0, bus.trap}, 32'd1);
        chk("int_epc", bus.epc_out, 32'h40);
        rd(ADDR_STATUS, v); chk("int_ie0", v, 32'h100);
        rd(ADDR_CAUSE, v);  chk("int_cause", v, 32'h100);
        step();
        chk("int_pulse1", {31'd0, bus.trap}, 32'd0);

        // eret re-enables; still-pending line traps again
        bus.eret = 1'b1;
        step();
        idle();
        bus.pc = 32'h44;
        rd(ADDR_STATUS, v); chk("eret_ie1", v, 32'h101);
        chk("eret_notrap", {31'd0, bus.trap}, 32'd0);
        step();
        chk("eret_trap2", {31'd0, bus.trap}, 32'd1);
        chk("eret_epc2", bus.epc_out, 32'h44);
        step();
        bus.irq = '0; bus.eret = 1'b1;
        step();
        idle();
        step();
        chk("irq_gone", {31'd0, bus.trap}, 32'd0);

        // exception and interrupt on the same edge
        wr(ADDR_STATUS, 32'h0000_0303);
        bus.irq = 6'b000010;
        step();
        idle();
        bus.exc_req = 1'b1; bus.exc_code = EXC_OV; bus.pc = 32'h80;
        step();
        bus.exc_req = 1'b0;
        chk("prio_trap", {31'd0, bus.trap}, 32'd1);
        rd(ADDR_CAUSE, v); chk("prio_cause", v, 32'h230);
        chk("prio_epc", bus.epc_out, 32'h80);
        step();
        chk("prio_single", {31'd0, bus.trap}, 32'd0);
        bus.irq = '0; bus.eret = 1'b1;
        step();
        idle();
        step();

        // edge line latched while masked, then cleared by software
        wr(ADDR_STATUS, 32'h0000_0001);
        step();
        idle();
        bus.irq = 6'b000100;
        step();
        bus.irq = '0;
        step();
        rd(ADDR_CAUSE, v); chk("edge_held", (v >> 10) & 32'h1, 32'h1);
        chk("edge_notrap", {31'd0, bus.trap}, 32'd0);
        wr(ADDR_CAUSE, 32'h0);
        step();
        idle();
        rd(ADDR_CAUSE, v); chk("edge_clr", v, 32'h0);
        chk("edge_notrap2", {31'd0, bus.trap}, 32'd0);
        wr(ADDR_CAUSE, 32'h0);
        bus.irq = 6'b000100;
        step();
        idle();
        rd(ADDR_CAUSE, v); chk("edge_setwins", v, 32'h400);
        wr(ADDR_CAUSE, 32'h0);
        step();
        idle();
        rd(ADDR_CAUSE, v); chk("edge_clr_hold", v, 32'h0);
        bus.irq = '0;
        step();

        // ExcReq and Eret ignored in TRAP
        bus.exc_req = 1'b1; bus.exc_code = EXC_SYS; bus.pc = 32'h100;
        step();
        chk("sys_trap", {31'd0, bus.trap}, 32'd1);
        rd(ADDR_CAUSE, v); chk("sys_cause", v, 32'h20);
        bus.eret = 1'b1;
        step();
        idle();
        chk("trap_ignore", {31'd0, bus.trap}, 32'd0);
        rd(ADDR_STATUS, v); chk("eret_in_trap", v, 32'h0);

        // reset during TRAP
        wr(ADDR_STATUS, 32'h0000_0101);
        bus.irq = 6'b000001;
        step();
        idle();
        step();
        chk("rt_trap", {31'd0, bus.trap}, 32'd1);
        clrn = 1'b0;
        #1;
        chk("rt_abort", {31'd0, bus.trap}, 32'd0);
        rd(ADDR_STATUS, v); chk("rt_status", v, 32'h0);
        rd(ADDR_CAUSE, v);  chk("rt_cause", v, 32'h0);
        chk("rt_epc", bus.epc_out, 32'h0);
        step();
        clrn = 1'b1;
        step();
        chk("rt_nopulse", {31'd0, bus.trap}, 32'd0);
        step();
        chk("rt_nopulse2", {31'd0, bus.trap}, 32'd0);

        // first trap on the first edge after release
        clrn = 1'b0;
        bus.irq = '0;
        step();
        clrn = 1'b1;
        bus.exc_req = 1'b1; bus.exc_code = EXC_OV; bus.pc = 32'h200;
        step();
        idle();
        chk("first_trap", {31'd0, bus.trap}, 32'd1);
        chk("first_epc", bus.epc_out, 32'h200);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter W, default 32, datapath and CP0 register width.
REQ-002 Parameter NIRQ, default 6, external interrupt lines; legal range 1..8.
REQ-003 Parameter IRQ_EDGE, default 0 (all level), NIRQ-bit mask; bit set = line is rising-edge latched.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 Clrn  in  1  reset, asynchronous, active-low.
REQ-006 Irq  in  NIRQ  external interrupt requests, synchronous to Clk.
REQ-007 ExcReq  in  1  synchronous exception request from the pipeline.
REQ-008 ExcCode  in  5  cause code for ExcReq.
REQ-009 Pc  in  W  PC of the faulting or interrupted instruction.
REQ-010 Mtc0  in  1  write strobe for Wdata into the register selected by Addr.
REQ-011 Addr  in  5  CP0 register select: 12 STATUS, 13 CAUSE, 14 EPC.
REQ-012 Wdata  in  W  Mtc0 write data.
REQ-013 Eret  in  1  return-from-exception strobe.
REQ-014 Rdata  out  W  combinational read of the register selected by Addr; 0 for other addresses.
REQ-015 Trap  out  1  one-cycle pulse: redirect fetch to the handler.
REQ-016 EpcOut  out  W  current EPC, for the Eret target.

Function
REQ-017 STATUS: bit0 IE (global enable); bits [8+NIRQ-1:8] IM (per-line mask); all other bits read 0.
REQ-018 CAUSE: bits [6:2] ExcCode; bits [8+NIRQ-1:8] IP (pending); all other bits read 0.
REQ-019 IP, level line: follows Irq each cycle.
REQ-020 IP, edge line: set on an Irq 0->1 transition; held until cleared.
REQ-021 Edge IP bit clear: Mtc0 to CAUSE with that Wdata bit 0; set-and-clear in the same cycle leaves the bit set.
REQ-022 Interrupt condition: IE=1 and (IP & IM) nonzero.
REQ-023 FSM RUN: ExcReq, or the interrupt condition, causes a trap.
REQ-024 ExcReq has priority over an interrupt.
REQ-025 On trap: EPC<=Pc; ExcCode<=ExcCode input (ExcReq) or 0 (interrupt); IE<=0; next state TRAP.
REQ-026 FSM TRAP: Trap=1 for exactly that cycle; ExcReq and interrupts ignored; next state RUN unconditionally.
REQ-027 Eret in RUN: IE<=1 at the next edge; Eret in TRAP is ignored.
REQ-028 Trap and Mtc0 in the same cycle: the trap wins for EPC, ExcCode and IE; the Mtc0 updates all other fields.
REQ-029 Eret and Mtc0 to STATUS in the same cycle: Eret wins for IE.
REQ-030 Writes to read-only bits are discarded.
REQ-031 Trap latency: one cycle from the request edge to the Trap=1 cycle.

Reset
REQ-032 Clrn low, asynchronously: STATUS=0, CAUSE=0, EPC=0, FSM=RUN, Trap=0, edge-detect history=0.
REQ-033 Reset in TRAP aborts the trap; no pulse follows release.
REQ-034 First trap possible on the first edge after Clrn rises.

Structure
REQ-035 Package cp0_pkg holds the register address constants, ExcCode constants (INT=0, SYS=8, OV=12) and the field bit positions.
REQ-036 Sub-module cp0_reg: W-bit register with 2:1 load-select mux, enable and async active-low clear; instantiated for STATUS, CAUSE and EPC.

Verification
REQ-037 Mtc0 STATUS=0x0000_0101, Irq[0]=1 level, Pc=0x40 -> one-cycle Trap; EPC=0x40; ExcCode=0; IE=0; Rdata(13)[8]=1.
REQ-038 Same edge ExcReq with ExcCode=12 and unmasked Irq[1], Pc=0x80 -> single Trap; ExcCode=12; EPC=0x80.
REQ-039 IRQ_EDGE[2]=1, Irq[2] pulse while IM[2]=0 -> IP[2] stays 1; Mtc0 CAUSE=0 -> IP[2]=0; no Trap.
REQ-040 Trap followed by Eret in RUN -> IE=1 next cycle; a still-pending unmasked line -> second Trap one cycle later.
REQ-041 Clrn low during the TRAP cycle -> Trap=0 immediately; all registers 0; no Trap after release.
